hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock shared with PC and Buf1..Buf4.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 id_rs, id_rt  in  5 each  source registers of the instruction in ID (Inst[25:21], Inst[20:16]).
REQ-004 id_uses_rt  in  1  high when the ID instruction reads rt (R-type, beq, sw).
REQ-005 ex_rs, ex_rt  in  5 each  source registers held in Buf2 (EX stage).
REQ-006 ex_memread, ex_regwrite  in  1 each; ex_dst  in  5  EX-stage load flag, write flag and Mux1 destination.
REQ-007 mem_regwrite  in  1; mem_dst  in  5  MEM-stage (Buf3) write flag and destination.
REQ-008 wb_regwrite  in  1; wb_dst  in  5  WB-stage (Buf4) write flag and destination.
REQ-009 mem_redirect  in  1  CAND output OR Buf3 jump flag: taken branch or jump in MEM.
REQ-010 pc_we, buf1_we  out  1 each  write enables for PC and Buf1.
REQ-011 buf1_flush, buf2_flush, buf3_flush  out  1 each  synchronous clear (bubble) for Buf1, Buf2 and Buf3 at next edge.
REQ-012 fwd_a, fwd_b  out  2 each  ALU operand select: 00 register file, 10 Buf3 ALU result, 01 Mux3 output.
REQ-013 stall_cycles, stall_events, redirects  out  16 each  saturating performance counters.

Function
REQ-014 Register 0 never causes a hazard or forward; every comparison requires dst != 0 and the matching regwrite = 1.
REQ-015 The FSM has states RUN and STALL; hazard and redirect decisions are combinational on current inputs, and the state register updates at each edge.
REQ-016 hazard = (id_rs matches a hazard source) OR (id_uses_rt AND id_rt matches a hazard source); hazard sources are defined in REQ-030 and REQ-031.
REQ-017 Stall cycle (hazard = 1, mem_redirect = 0): pc_we = 0, buf1_we = 0, buf2_flush = 1, buf1_flush = 0, buf3_flush = 0.
REQ-018 Redirect cycle (mem_redirect = 1): pc_we = 1, buf1_we = 1, buf1_flush = buf2_flush = buf3_flush = 1; redirect overrides hazard.
REQ-019 Otherwise: pc_we = 1, buf1_we = 1, all flushes = 0.
REQ-020 Transitions: RUN->STALL on a stall cycle; STALL->STALL while the hazard persists; STALL->RUN when the hazard clears or on redirect.
REQ-021 stall_cycles increments in every stall cycle; stall_events increments only on the RUN->STALL transition; redirects increments in every redirect cycle.
REQ-022 All counters saturate at 16'hFFFF and never wrap.
REQ-023 A redirect and a hazard in the same cycle: only redirects increments, and the next state is RUN.

Reset
REQ-024 While rst_n = 0 at an edge: state = RUN and all counters = 0.
REQ-025 While rst_n = 0, outputs are forced: pc_we = 0, buf1_we = 0, all flushes = 1, fwd_a = fwd_b = 00.
REQ-026 Reset during STALL aborts the stall; after the first edge with rst_n = 1, the block is in RUN and behaves per REQ-019.

Configuration
REQ-027 Macro HAZARD_CTRL_FORWARD_EN selects the forwarding build.
REQ-028 Defined, fwd_a: 10 if mem_regwrite and mem_dst == ex_rs; else 01 if wb_regwrite and wb_dst == ex_rs; else 00. Same rules for fwd_b with ex_rt; the MEM stage wins.
REQ-029 Not defined, fwd_a = fwd_b = 00 constantly.
REQ-030 Defined, the only hazard source is ex_dst with ex_memread = 1 (load-use): exactly a 1-cycle stall.
REQ-031 Not defined, the hazard sources are ex_dst, mem_dst and wb_dst (each gated by its regwrite): stall of up to 3 cycles until the producer retires.

Verification
REQ-032 Reset: rst_n = 0 for 2 cycles, then 1 -> during reset pc_we = 0 and flushes = 1; the cycle after release pc_we = 1, counters = 0.
REQ-033 FORWARD_EN, lw $8 in EX (ex_memread = 1, ex_dst = 8), add using $8 in ID -> one stall cycle with buf2_flush = 1; stall_cycles = 1, stall_events = 1.
REQ-034 FORWARD_EN, mem_dst = 9, wb_dst = 9, ex_rs = 9, both regwrite = 1 -> fwd_a = 10; with mem_regwrite = 0 -> fwd_a = 01.
REQ-035 No FORWARD_EN, add $10 in EX, dependent sub in ID, producer advances each cycle -> 3 stall cycles; stall_cycles = 3, stall_events = 1.
REQ-036 mem_redirect = 1 while stalling -> all three flushes = 1, pc_we = 1, next state RUN, redirects = 1.
REQ-037 Saturation: force 70000 stall cycles -> stall_cycles holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/redirect decisions, operand forwarding and perf counters.
// Define HAZARD_CTRL_FORWARD_EN for the forwarding build (load-use stalls only).
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic        ex_memread,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_dst,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_dst,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_dst,
    input  logic        mem_redirect,
    output logic        pc_we,
    output logic        buf1_we,
    output logic        buf1_flush,
    output logic        buf2_flush,
    output logic        buf3_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cycles,
    output logic [15:0] stall_events,
    output logic [15:0] redirects
);

    typedef enum logic {RUN, STALL} state_t;

    state_t      r_state;
    logic [15:0] r_stall_cycles;
    logic [15:0] r_stall_events;
    logic [15:0] r_redirects;

    logic        w_hazard;
    logic        w_stall;
    logic        w_redirect;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;

    // Register 0 is hardwired, so it never produces a dependency.
    function automatic logic dep(input logic [4:0] src, input logic [4:0] dst, input logic we);
        return we && (dst != 5'd0) && (src == dst);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

`ifdef HAZARD_CTRL_FORWARD_EN
    function automatic logic hz_src(input logic [4:0] src);
        return dep(src, ex_dst, ex_regwrite && ex_memread);
    endfunction

    // MEM result is younger than WB, so it takes priority.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (dep(src, mem_dst, mem_regwrite))
            return 2'b10;
        else if (dep(src, wb_dst, wb_regwrite))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_fwd_a = fwd_sel(ex_rs);
    assign w_fwd_b = fwd_sel(ex_rt);
`else
    // Without forwarding the consumer waits until the producer leaves WB.
    function automatic logic hz_src(input logic [4:0] src);
        return dep(src, ex_dst, ex_regwrite) || dep(src, mem_dst, mem_regwrite) ||
               dep(src, wb_dst, wb_regwrite);
    endfunction

    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{ex_rs, ex_rt, ex_memread};
    assign w_fwd_a = 2'b00;
    assign w_fwd_b = 2'b00;
`endif

    assign w_hazard   = hz_src(id_rs) || (id_uses_rt && hz_src(id_rt));
    assign w_redirect = mem_redirect;
    assign w_stall    = w_hazard && !mem_redirect;

    always_comb begin
        pc_we      = 1'b1;
        buf1_we    = 1'b1;
        buf1_flush = 1'b0;
        buf2_flush = 1'b0;
        buf3_flush = 1'b0;
        fwd_a      = w_fwd_a;
        fwd_b      = w_fwd_b;
        if (!rst_n) begin
            pc_we      = 1'b0;
            buf1_we    = 1'b0;
            buf1_flush = 1'b1;
            buf2_flush = 1'b1;
            buf3_flush = 1'b1;
            fwd_a      = 2'b00;
            fwd_b      = 2'b00;
        end else if (w_redirect) begin
            buf1_flush = 1'b1;
            buf2_flush = 1'b1;
            buf3_flush = 1'b1;
        end else if (w_stall) begin
            // Hold PC/Buf1 and inject a bubble into EX.
            pc_we      = 1'b0;
            buf1_we    = 1'b0;
            buf2_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_stall_cycles <= 16'd0;
            r_stall_events <= 16'd0;
            r_redirects    <= 16'd0;
        end else begin
            r_state <= w_stall ? STALL : RUN;
            if (w_stall)
                r_stall_cycles <= sat_inc(r_stall_cycles);
            if (w_stall && (r_state == RUN))
                r_stall_events <= sat_inc(r_stall_events);
            if (w_redirect)
                r_redirects <= sat_inc(r_redirects);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign stall_events = r_stall_events;
    assign redirects    = r_redirects;

endmodule
